// File: rtl/ac_motor_pkg.sv
// Shared widths, config-word field positions and the config struct for the
// V/f set-point generator.
package ac_motor_pkg;
   localparam int POWER_W   = 12;
   localparam int DELAY_W   = 11;
   localparam int UMIN_W    = 4;
   localparam int CFG_W     = 16;
   localparam int MOD_BIT   = 15;
   localparam int DELAY_MSB = 14;
   localparam int DELAY_LSB = 4;
   localparam int UMIN_MSB  = 3;
   localparam int UMIN_LSB  = 0;

   typedef struct packed {
      logic               modulation;
      logic [DELAY_W-1:0] delay;
      logic [UMIN_W-1:0]  umin;
   } cfg_t;

   // The 4-bit minimum-voltage code scales to the top nibble of the amplitude.
   function automatic logic [POWER_W-1:0] umin_floor(input logic [UMIN_W-1:0] umin);
      return {umin, 8'h00};
   endfunction
endpackage

// File: rtl/ac_motor_ramp.sv
// Ramp prescaler plus saturating slew limiter: moves frequency toward target
// by at most RAMP_STEP once every RAMP_DIV cycles, never overshooting.
module ac_motor_ramp
   import ac_motor_pkg::*;
#(
   parameter int unsigned RAMP_DIV  = 2,
   parameter int unsigned RAMP_STEP = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [POWER_W-1:0] target,
   output logic [POWER_W-1:0] frequency
);
   localparam logic [15:0]      CNT_LAST = 16'(RAMP_DIV - 1);
   localparam logic [POWER_W:0] STEP_EXT = (POWER_W + 1)'(RAMP_STEP);

   logic [15:0]        cnt;
   logic               tick;
   logic [POWER_W:0]   up_sum;
   logic [POWER_W:0]   dn_diff;
   logic [POWER_W:0]   tgt_ext;
   logic [POWER_W-1:0] next_freq;

   assign tick = (cnt == CNT_LAST);

   // 13-bit arithmetic: a borrow shows up in the top bit of dn_diff, and any
   // step past the target is clamped to the target, which also bounds 0..4095.
   always_comb begin
      tgt_ext   = {1'b0, target};
      up_sum    = {1'b0, frequency} + STEP_EXT;
      dn_diff   = {1'b0, frequency} - STEP_EXT;
      next_freq = frequency;
      if (frequency < target) begin
         next_freq = (up_sum > tgt_ext) ? target : up_sum[POWER_W-1:0];
      end else if (frequency > target) begin
         next_freq = (dn_diff[POWER_W] || (dn_diff < tgt_ext)) ? target : dn_diff[POWER_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         frequency <= '0;
      end else begin
         cnt <= tick ? 16'd0 : cnt + 16'd1;
         if (tick) begin
            frequency <= next_freq;
         end
      end
   end
endmodule

// File: rtl/ac_motor_control.sv
// Open-loop V/f set-point generator: slew-limited frequency, amplitude with a
// minimum-voltage floor, and registered modulation/dead-time config fields.
module ac_motor_control
   import ac_motor_pkg::*;
#(
   parameter int unsigned RAMP_DIV  = 2,
   parameter int unsigned RAMP_STEP = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [POWER_W-1:0] power,
   input  logic [CFG_W-1:0]   mod_delay_umin,
   output logic               modulation,
   output logic [DELAY_W-1:0] delay,
   output logic [POWER_W-1:0] frequency,
   output logic [POWER_W-1:0] amplitude
);
   cfg_t               cfg_in;
   logic [UMIN_W-1:0]  umin;
   logic [POWER_W-1:0] floor_v;
   logic [POWER_W-1:0] amp_next;

   assign cfg_in.modulation = mod_delay_umin[MOD_BIT];
   assign cfg_in.delay      = mod_delay_umin[DELAY_MSB:DELAY_LSB];
   assign cfg_in.umin       = mod_delay_umin[UMIN_MSB:UMIN_LSB];

   ac_motor_ramp #(
      .RAMP_DIV  (RAMP_DIV),
      .RAMP_STEP (RAMP_STEP)
   ) u_ramp (
      .clk       (clk),
      .reset     (reset),
      .target    (power),
      .frequency (frequency)
   );

   // A stopped motor gets no voltage boost; otherwise the floor applies.
   always_comb begin
      floor_v  = umin_floor(umin);
      amp_next = '0;
      if (frequency != '0) begin
         amp_next = (frequency > floor_v) ? frequency : floor_v;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         modulation <= 1'b0;
         delay      <= '0;
         umin       <= '0;
         amplitude  <= '0;
      end else begin
         modulation <= cfg_in.modulation;
         delay      <= cfg_in.delay;
         umin       <= cfg_in.umin;
         amplitude  <= amp_next;
      end
   end
endmodule

// File: tb/tb_ac_motor_control.sv
// Bench for ac_motor_control: two instances (slow unit-step ramp and fast
// 16-step ramp) checked cycle by cycle against an arithmetic reference model.
module tb_ac_motor_control;
   logic        clk;
   logic        reset;
   logic [11:0] power_a, power_b;
   logic [15:0] cfg_a, cfg_b;
   logic        mod_a, mod_b;
   logic [10:0] delay_a, delay_b;
   logic [11:0] freq_a, freq_b, amp_a, amp_b;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int         freq;
      int         amp;
      int         umin;
      int         cyc;
      logic       md;
      logic [10:0] dly;
   } mstate_t;

   mstate_t ma, mb;
   logic [35:0] exp_qa[$];
   logic [35:0] exp_qb[$];

   ac_motor_control #(.RAMP_DIV(2), .RAMP_STEP(1)) dut_a (
      .clk(clk), .reset(reset), .power(power_a), .mod_delay_umin(cfg_a),
      .modulation(mod_a), .delay(delay_a), .frequency(freq_a), .amplitude(amp_a)
   );

   ac_motor_control #(.RAMP_DIV(1), .RAMP_STEP(16)) dut_b (
      .clk(clk), .reset(reset), .power(power_b), .mod_delay_umin(cfg_b),
      .modulation(mod_b), .delay(delay_b), .frequency(freq_b), .amplitude(amp_b)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: one call per rising edge
   function automatic mstate_t model_step(input mstate_t s, input logic rst, input int pwr,
                                          input logic [15:0] cfg, input int div, input int step);
      mstate_t n;
      int fl;
      n = s;
      if (rst) begin
         n.freq = 0; n.amp = 0; n.umin = 0; n.cyc = 0; n.md = 1'b0; n.dly = '0;
      end else begin
         fl = s.umin * 256;
         n.amp = (s.freq == 0) ? 0 : ((s.freq > fl) ? s.freq : fl);
         if ((s.cyc % div) == div - 1) begin
            if (s.freq < pwr)      n.freq = (s.freq + step > pwr) ? pwr : s.freq + step;
            else if (s.freq > pwr) n.freq = (s.freq - step < pwr) ? pwr : s.freq - step;
         end
         n.md   = cfg[15];
         n.dly  = cfg[14:4];
         n.umin = int'(cfg[3:0]);
         n.cyc  = s.cyc + 1;
      end
      return n;
   endfunction

   function automatic logic [35:0] pack(input mstate_t s);
      return {s.md, s.dly, 12'(s.freq), 12'(s.amp)};
   endfunction

   initial begin
      ma = '{default: 0};
      mb = '{default: 0};
   end

   always @(posedge clk) begin
      ma = model_step(ma, reset, int'(power_a), cfg_a, 2, 1);
      mb = model_step(mb, reset, int'(power_b), cfg_b, 1, 16);
      exp_qa.push_back(pack(ma));
      exp_qb.push_back(pack(mb));
   end

   // scoreboard monitor
   always @(negedge clk) begin
      logic [35:0] e, g;
      if (exp_qa.size() > 0) begin
         e = exp_qa.pop_front();
         g = {mod_a, delay_a, freq_a, amp_a};
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL sb_a t=%0t got=%h exp=%h", $time, g, e);
         end
      end
      if (exp_qb.size() > 0) begin
         e = exp_qb.pop_front();
         g = {mod_b, delay_b, freq_b, amp_b};
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL sb_b t=%0t got=%h exp=%h", $time, g, e);
         end
      end
   end

   // directed checks and driver tasks
   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", name, act, exp);
      end
   endtask

   task automatic wait_freq(input bit sel, input int target, input int budget, input string name);
      int  n;
      bit  hit;
      n   = 0;
      hit = 1'b0;
      while (!hit && n < budget) begin
         @(negedge clk);
         n++;
         hit = sel ? (int'(freq_b) == target) : (int'(freq_a) == target);
      end
      total++;
      if (!hit) begin
         bad++;
         $display("FAIL %s timeout got=%0d exp=%0d", name, sel ? int'(freq_b) : int'(freq_a), target);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset   = 1'b1;
      power_a = 12'd4095;
      cfg_a   = 16'hFFFF;
      power_b = 12'd10;
      cfg_b   = 16'h0000;
      cycles(3);
      chk("rst_mod", int'(mod_a), 0);
      chk("rst_delay", int'(delay_a), 0);
      chk("rst_freq", int'(freq_a), 0);
      chk("rst_amp", int'(amp_a), 0);

      reset = 1'b0;
      cycles(1);
      chk("cfg_mod", int'(mod_a), 1);
      chk("cfg_delay", int'(delay_a), 2047);
      chk("first_freq", int'(freq_a), 0);
      chk("clamp_up_b", int'(freq_b), 10);
      power_b = 12'd0;
      cycles(1);
      chk("clamp_zero_b", int'(freq_b), 0);
      power_b = 12'd4090;

      cycles(8187);
      chk("ramp_4094", int'(freq_a), 4094);
      cycles(1);
      chk("ramp_4095", int'(freq_a), 4095);
      chk("hold_4090_b", int'(freq_b), 4090);
      power_b = 12'd4095;
      cycles(1);
      chk("clamp_top_b", int'(freq_b), 4095);
      cycles(20);
      chk("no_wrap", int'(freq_a), 4095);

      cfg_a = 16'hFF00;
      cycles(1);
      chk("ff00_mod", int'(mod_a), 1);
      chk("ff00_delay", int'(delay_a), 2032);
      cycles(1);
      chk("ff00_amp", int'(amp_a), 4095);

      power_a = 12'd3000;
      wait_freq(1'b0, 3000, 2300, "down_3000");
      power_a = 12'd2047;
      wait_freq(1'b0, 2047, 2000, "down_2047");
      cycles(10);
      chk("hold_2047", int'(freq_a), 2047);
      power_a = 12'd2100;
      wait_freq(1'b0, 2048, 3, "reverse");

      cfg_a   = 16'h80FE;
      power_a = 12'd100;
      wait_freq(1'b0, 100, 4200, "to_100");
      cycles(2);
      chk("floor_amp", int'(amp_a), 3584);
      chk("floor_mod", int'(mod_a), 1);
      chk("floor_delay", int'(delay_a), 15);
      power_a = 12'd3700;
      wait_freq(1'b0, 3700, 7300, "to_3700");
      cycles(2);
      chk("above_floor_amp", int'(amp_a), 3700);
      power_a = 12'd0;
      wait_freq(1'b0, 0, 7500, "to_0");
      chk("stop_amp_lag", int'(amp_a), 3584);
      cycles(1);
      chk("stop_amp", int'(amp_a), 0);

      power_a = 12'd4095;
      cycles(50);
      reset = 1'b1;
      cycles(2);
      reset = 1'b0;
      cycles(1);
      chk("midramp_reset", int'(freq_a), 0);

      for (int i = 0; i < 300; i++) begin
         int r;
         r = int'($urandom_range(0, 7));
         power_a = (r == 0) ? 12'd0 : (r == 1) ? 12'd4095 : 12'($urandom_range(0, 4095));
         r = int'($urandom_range(0, 7));
         power_b = (r == 0) ? 12'd0 : (r == 1) ? 12'd4095 : 12'($urandom_range(0, 4095));
         cfg_a = 16'($urandom);
         cfg_b = 16'($urandom);
         if ($urandom_range(0, 39) == 0) reset = 1'b1;
         cycles(int'($urandom_range(1, 40)));
         reset = 1'b0;
      end

      cycles(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
